// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter: FSM encoding,
// default widths and a constant-evaluable clog2.
package apb_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TMO     = 16;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Shared APB master user-side command port. The arbiter drives the command
// through the master modport; the APB master top attaches via slave.
interface apb_req_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              start_transfer;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              valid;

  modport master (
    output start_transfer, rw, addr, wdata,
    input  rdata, busy, valid
  );

  modport slave (
    input  start_transfer, rw, addr, wdata,
    output rdata, busy, valid
  );
endinterface

// File: rtl/apb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching from
// last+1 upward, modulo NUM_REQ.
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB master command port among NUM_REQ clients.
// Optional WAIT watchdog with done_err is compiled in by ARB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_width     = DEF_ADDR_W,
  parameter int DATA_width     = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TMO
) (
  input  logic                                 P_clk,
  input  logic                                 P_reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_rw,
  input  logic [NUM_REQ-1:0][ADDR_width-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_width-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   done,
  output logic                                 done_err,
  output logic [DATA_width-1:0]                rdata_out,
  apb_req_arbiter_if.master                    apb
);
  localparam int IDX_W = clog2(NUM_REQ);

  localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(ST_IDLE);
  localparam logic [STATE_W-1:0] S_ISSUE = STATE_W'(ST_ISSUE);
  localparam logic [STATE_W-1:0] S_WAIT  = STATE_W'(ST_WAIT);
  localparam logic [STATE_W-1:0] S_DONE  = STATE_W'(ST_DONE);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [IDX_W-1:0]      last_q, win_q;
  logic [NUM_REQ-1:0]    gnt_q, done_q;
  logic                  err_q, start_q, rw_q;
  logic [ADDR_width-1:0] addr_q;
  logic [DATA_width-1:0] wdata_q, rdata_q;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  tmo_hit;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Limit fires on the TIMEOUT_CYCLES-th WAIT cycle; a valid on that cycle wins.
  assign tmo_hit = (state_q == S_WAIT) && !apb.valid &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge P_clk or posedge P_reset) begin
    if (P_reset)                 tmo_q <= '0;
    else if (state_q != S_WAIT)  tmo_q <= '0;
    else if (!tmo_hit)           tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_any)                 state_d = S_ISSUE;
      S_ISSUE: if (!apb.busy)                state_d = S_WAIT;
      S_WAIT:  if (apb.valid || tmo_hit)     state_d = S_DONE;
      default:                               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge P_clk or posedge P_reset) begin
    if (P_reset) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        S_IDLE: if (pick_any) begin
          gnt_q   <= pick_oh;
          win_q   <= pick_idx;
          rw_q    <= req_rw[pick_idx];
          addr_q  <= req_addr[pick_idx];
          wdata_q <= req_wdata[pick_idx];
        end
        S_ISSUE: start_q <= !apb.busy;
        S_WAIT: begin
          if (apb.valid) begin
            rdata_q <= apb.rdata;
            done_q  <= gnt_q;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            done_q  <= gnt_q;
          end
        end
        default: begin
          gnt_q  <= '0;
          err_q  <= 1'b0;
          last_q <= win_q;
        end
      endcase
    end
  end

  assign gnt                = gnt_q;
  assign done               = done_q;
  assign done_err           = err_q;
  assign rdata_out          = rdata_q;
  assign apb.start_transfer = start_q;
  assign apb.rw             = rw_q;
  assign apb.addr           = addr_q;
  assign apb.wdata          = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: single grant, round-robin order,
// read-back, busy stall, mid-transfer reset and WAIT watchdog behaviour.
module tb_apb_req_arbiter;
  logic            P_clk = 1'b0;
  logic            P_reset;
  logic [3:0]      req, req_rw;
  logic [3:0][3:0] req_addr;
  logic [3:0][7:0] req_wdata;
  logic [3:0]      gnt, done;
  logic            done_err;
  logic [7:0]      rdata_out;
  logic [7:0]      mem [16];
  int              n_chk = 0;
  int              n_err = 0;

  apb_req_arbiter_if #(.ADDR_W(4), .DATA_W(8)) apb ();

  apb_req_arbiter #(.NUM_REQ(4), .ADDR_width(4), .DATA_width(8), .TIMEOUT_CYCLES(16)) dut (
    .P_clk     (P_clk),
    .P_reset   (P_reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .done_err  (done_err),
    .rdata_out (rdata_out),
    .apb       (apb)
  );

  always #5 P_clk = ~P_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge P_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [3:0] a, input logic [7:0] wd);
    req_rw[i]    = rw;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    req[i]       = 1'b1;
  endtask

  // Walks one full transfer from IDLE; the slave returns mem[addr] as rdata.
  task automatic serve(input int who, input logic rw_e, input logic [3:0] a_e,
                       input logic [7:0] wd_e, input int busy_n, input bit drop);
    logic [3:0] oh;
    logic [7:0] rd_e;
    oh   = 4'(1 << who);
    rd_e = mem[a_e];
    apb.busy = (busy_n > 0);
    tick();
    chk("gnt", gnt, oh);
    chk("gnt_onehot", 32'($onehot(gnt)), 1);
    chk("start_at_grant", apb.start_transfer, 0);
    for (int k = 0; k < busy_n; k++) begin
      tick();
      chk("start_busy", apb.start_transfer, 0);
      chk("addr_hold", apb.addr, a_e);
      chk("wdata_hold", apb.wdata, wd_e);
    end
    apb.busy = 1'b0;
    tick();
    chk("start", apb.start_transfer, 1);
    chk("rw", apb.rw, rw_e);
    chk("addr", apb.addr, a_e);
    chk("wdata", apb.wdata, wd_e);
    tick();
    chk("start_one_cycle", apb.start_transfer, 0);
    chk("no_early_done", done, 0);
    apb.rdata = rd_e;
    apb.valid = 1'b1;
    if (rw_e) mem[a_e] = wd_e;
    tick();
    apb.valid = 1'b0;
    apb.rdata = 8'hEE;
    chk("done", done, oh);
    chk("rdata_out", rdata_out, rd_e);
    chk("done_err", done_err, 0);
    chk("gnt_in_done", gnt, oh);
    if (drop) req[who] = 1'b0;
    tick();
    chk("done_pulse", done, 0);
    chk("gnt_clear", gnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[9] = 8'h3C;
    P_reset = 1'b1;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    apb.rdata = '0; apb.busy = 1'b0; apb.valid = 1'b0;
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_start", apb.start_transfer, 0);
    chk("rst_rdata", rdata_out, 0);
    tick();
    P_reset = 1'b0;

    // single write from requester 0
    set_req(0, 1'b1, 4'h3, 8'hA5);
    serve(0, 1'b1, 4'h3, 8'hA5, 0, 1'b1);
    tick();
    chk("idle_gnt", gnt, 0);

    // all requesting continuously from a fresh pointer: 0,1,2,3,0
    P_reset = 1'b1; tick(); P_reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 4), 8'(8'h10 + i));
    serve(0, 1'b1, 4'h4, 8'h10, 0, 1'b0);
    serve(1, 1'b1, 4'h5, 8'h11, 0, 1'b0);
    serve(2, 1'b1, 4'h6, 8'h12, 0, 1'b0);
    serve(3, 1'b1, 4'h7, 8'h13, 0, 1'b0);
    serve(0, 1'b1, 4'h4, 8'h10, 0, 1'b0);
    req = '0;

    // requester 2 reads back the earlier write
    set_req(2, 1'b0, 4'h3, 8'h00);
    serve(2, 1'b0, 4'h3, 8'h00, 0, 1'b1);
    chk("readback_a5", rdata_out, 8'hA5);

    // busy held five cycles after grant
    set_req(1, 1'b0, 4'h9, 8'h5A);
    serve(1, 1'b0, 4'h9, 8'h5A, 5, 1'b1);
    chk("busy_rd", rdata_out, 8'h3C);

    // reset pulse in WAIT
    set_req(3, 1'b1, 4'h2, 8'h77);
    tick();
    chk("r_gnt3", gnt, 4'b1000);
    tick();
    chk("r_start", apb.start_transfer, 1);
    set_req(0, 1'b0, 4'h3, 8'h00);
    P_reset = 1'b1;
    #1;
    chk("r_gnt0", gnt, 0);
    chk("r_start0", apb.start_transfer, 0);
    chk("r_addr0", apb.addr, 0);
    chk("r_wdata0", apb.wdata, 0);
    chk("r_rdata0", rdata_out, 0);
    apb.valid = 1'b1;
    tick();
    apb.valid = 1'b0;
    chk("r_nodone", done, 0);
    P_reset = 1'b0;
    serve(0, 1'b0, 4'h3, 8'h00, 0, 1'b1);
    req = '0;
    chk("r_mem_untouched", mem[2], 0);

    // requester 2 with the slave never answering
    set_req(2, 1'b0, 4'h3, 8'h00);
    tick();
    chk("t_gnt", gnt, 4'b0100);
    tick();
    chk("t_start", apb.start_transfer, 1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t_nodone", done, 0);
    end
    tick();
    chk("t_done", done, 4'b0100);
    chk("t_err", done_err, 1);
    chk("t_rdata0", rdata_out, 0);
    req[2] = 1'b0;
    tick();
    chk("t_done_clr", done, 0);
    chk("t_err_clr", done_err, 0);
`else
    for (int k = 0; k < 40; k++) tick();
    chk("t_stuck_done", done, 0);
    chk("t_stuck_gnt", gnt, 4'b0100);
    chk("t_stuck_err", done_err, 0);
    chk("t_stuck_rd", rdata_out, 8'hA5);
    req[2] = 1'b0;
    P_reset = 1'b1; tick(); P_reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
